// File: rtl/aes_pkg.sv
// AES GF(2^8) helpers shared by the MixColumns pipeline.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package aes_pkg;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_col_t;

  // Multiply by x (i.e. by 2) in GF(2^8).
  function automatic aes_byte_t xt(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// One-column MixColumns datapath: inverse pre-conditioning and forward mix.
// Latency: purely combinational.
// Backpressure: none; the instantiating stage decides when results are used.
//
// Ports:
//   col_i : input column, byte 0 in [31:24]
//   pre_o : column pre-conditioned so that a forward mix yields InvMixColumns
//   fwd_o : forward MixColumns of col_i
module aes_mixcol_col
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  output aes_col_t pre_o,
  output aes_col_t fwd_o
);

  aes_byte_t a, b, c, d;
  aes_byte_t w, v, t;

  always_comb begin
    a = col_i[31:24];
    b = col_i[23:16];
    c = col_i[15:8];
    d = col_i[7:0];

    // InvMixColumns = MixColumns * {05,00,04,00} circulant; that matrix
    // reduces to adding 4*(a^c) to the even bytes and 4*(b^d) to the odd ones.
    w = xt(xt(a ^ c));
    v = xt(xt(b ^ d));
    pre_o = {a ^ w, b ^ v, c ^ w, d ^ v};

    // 2*s0 ^ 3*s1 ^ s2 ^ s3 rewritten as s0 ^ (s0^s1^s2^s3) ^ 2*(s0^s1),
    // sharing the column parity t across all four bytes.
    t = a ^ b ^ c ^ d;
    fwd_o = {a ^ t ^ xt(a ^ b),
             b ^ t ^ xt(b ^ c),
             c ^ t ^ xt(c ^ d),
             d ^ t ^ xt(d ^ a)};
  end

endmodule

// File: rtl/aes_mixcolumns_pipe.sv
// Two-stage pipelined AES MixColumns / InvMixColumns / bypass over NCOL columns.
// Latency: 2 cycles from input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: valid/ready with bubble collapsing; in_ready is combinational
//   from out_ready, so a full pipe still accepts when the output drains.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_data              : NCOL columns, column 0 in the MSBs
//   in_inv, in_bypass    : per-beat mode (bypass overrides inv)
//   in_last              : sideband tag carried with the beat
//   out_valid/out_ready  : output handshake
//   out_data, out_last   : result columns and tag
//   beat_cnt             : saturating count of completed output beats
module aes_mixcolumns_pipe
  import aes_pkg::*;
#(
  parameter int NCOL  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*NCOL-1:0]   in_data,
  input  logic                 in_inv,
  input  logic                 in_bypass,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NCOL-1:0]   out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int DW = 32 * NCOL;

  // S1: pre-conditioned data plus the bypass flag S2 needs.
  logic          v1_q, v1_d;
  logic [DW-1:0] d1_q, d1_d;
  logic          byp1_q, byp1_d;
  logic          last1_q, last1_d;

  // S2: final result presented on the output.
  logic          v2_q, v2_d;
  logic [DW-1:0] d2_q, d2_d;
  logic          last2_q, last2_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0] s1_col, s2_col;
  logic [DW-1:0] s1_fwd_unused, s2_pre_unused;

  logic s1_load, s2_load, in_fire, out_fire;

  // Each stage refills whenever it is empty or its contents move on.
  assign s2_load  = !v2_q || out_ready;
  assign s1_load  = !v1_q || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && s1_load;
  assign out_fire = v2_q && out_ready;

  for (genvar g = 0; g < NCOL; g++) begin : g_col
    localparam int HI = DW - 1 - 32 * g;
    aes_col_t pre_w;
    aes_col_t fwd_w;

    aes_mixcol_col u_s1 (
      .col_i (in_data[HI -: 32]),
      .pre_o (pre_w),
      .fwd_o (s1_fwd_unused[HI -: 32])
    );

    aes_mixcol_col u_s2 (
      .col_i (d1_q[HI -: 32]),
      .pre_o (s2_pre_unused[HI -: 32]),
      .fwd_o (fwd_w)
    );

    assign s1_col[HI -: 32] = (in_inv && !in_bypass) ? pre_w : in_data[HI -: 32];
    assign s2_col[HI -: 32] = byp1_q ? d1_q[HI -: 32] : fwd_w;
  end

  always_comb begin
    v1_d    = v1_q;
    d1_d    = d1_q;
    byp1_d  = byp1_q;
    last1_d = last1_q;
    v2_d    = v2_q;
    d2_d    = d2_q;
    last2_d = last2_q;
    cnt_d   = cnt_q;

    if (s1_load) begin
      v1_d = in_valid;
    end
    if (in_fire) begin
      d1_d    = s1_col;
      byp1_d  = in_bypass;
      last1_d = in_last;
    end

    if (s2_load) begin
      v2_d = v1_q;
    end
    // Data only moves with a real beat so a bubble never overwrites a
    // result that is still held under backpressure.
    if (s2_load && v1_q) begin
      d2_d    = s2_col;
      last2_d = last1_q;
    end

    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      d1_q    <= '0;
      byp1_q  <= 1'b0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
      last2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      byp1_q  <= byp1_d;
      last1_q <= last1_d;
      v2_q    <= v2_d;
      d2_q    <= d2_d;
      last2_q <= last2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = d2_q;
  assign out_last  = last2_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_aes_mixcolumns_pipe.sv
// Self-checking bench for aes_mixcolumns_pipe: known-answer tables on a
// 4-column and a 1-column (2-bit counter) instance, directed streaming,
// stall and reset sequences, and a randomized scoreboard run.
module tb_aes_mixcolumns_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: NCOL=4, CNT_W=16
  logic         a_in_valid, a_in_ready, a_in_inv, a_in_bypass, a_in_last;
  logic         a_out_valid, a_out_ready, a_out_last;
  logic [127:0] a_in_data, a_out_data;
  logic [15:0]  a_beat_cnt;

  // Instance B: NCOL=1, CNT_W=2
  logic         b_in_valid, b_in_ready, b_in_inv, b_in_bypass, b_in_last;
  logic         b_out_valid, b_out_ready, b_out_last;
  logic [31:0]  b_in_data, b_out_data;
  logic [1:0]   b_beat_cnt;

  aes_mixcolumns_pipe #(.NCOL(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_inv(a_in_inv), .in_bypass(a_in_bypass), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .beat_cnt(a_beat_cnt)
  );

  aes_mixcolumns_pipe #(.NCOL(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_inv(b_in_inv), .in_bypass(b_in_bypass), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .beat_cnt(b_beat_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic         byp;
    logic [127:0] dout;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic         inv;
    logic         byp;
    logic         last;
  } beat_t;

  beat_t        src_q[$];
  logic [128:0] exp_q[$];
  int           n_out = 0;
  logic         stall_prev = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;

  // ---------------- reference model ----------------
  // Carry-less product followed by reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = 16'h0;
    for (int k = 0; k < 8; k++)
      if (y[k]) p = p ^ (16'(x) << k);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  // Matrix-times-column with the circulant coefficient rows from FIPS-197.
  function automatic logic [31:0] model_col(input logic [31:0] col, input logic inv, input logic byp);
    logic [7:0] s [4];
    logic [7:0] m [4];
    logic [7:0] o;
    logic [31:0] r;
    if (byp) return col;
    for (int j = 0; j < 4; j++) s[j] = col[31 - 8*j -: 8];
    if (inv) begin m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      o = 8'h00;
      for (int j = 0; j < 4; j++) o = o ^ gmul(m[(j - i + 4) % 4], s[j]);
      r[31 - 8*i -: 8] = o;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_beat(input logic [127:0] d, input logic inv, input logic byp);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = model_col(d[127 - 32*c -: 32], inv, byp);
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [127:0] d, input logic inv, input logic byp, input logic last);
    beat_t b;
    b.d = d; b.inv = inv; b.byp = byp; b.last = last;
    src_q.push_back(b);
  endtask

  // One clock of instance A traffic with scoreboard and hold checking.
  task automatic cycle_a(input bit offer, input bit ordy, output bit ir, output bit ov);
    logic [128:0] e;
    a_in_valid  = offer && (src_q.size() > 0);
    if (a_in_valid) begin
      a_in_data   = src_q[0].d;
      a_in_inv    = src_q[0].inv;
      a_in_bypass = src_q[0].byp;
      a_in_last   = src_q[0].last;
    end
    a_out_ready = ordy;
    #1;
    ir = a_in_ready;
    ov = a_out_valid;
    if (stall_prev) begin
      chk("hold_data", a_out_data, prev_data);
      chk("hold_last", 128'(a_out_last), 128'(prev_last));
    end
    stall_prev = a_out_valid && !a_out_ready;
    prev_data  = a_out_data;
    prev_last  = a_out_last;
    if (a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_out: got %h expected no beat", a_out_data);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", a_out_data, e[127:0]);
        chk("stream_last", 128'(a_out_last), 128'(e[128]));
      end
      n_out++;
    end
    if (a_in_valid && a_in_ready) begin
      exp_q.push_back({src_q[0].last, model_beat(src_q[0].d, src_q[0].inv, src_q[0].byp)});
      void'(src_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec_a(input vec_t v, input int idx);
    a_in_valid = 1'b1; a_in_data = v.din; a_in_inv = v.inv; a_in_bypass = v.byp;
    a_in_last = idx[0]; a_out_ready = 1'b1;
    #1 chk($sformatf("vecA%0d_in_ready", idx), 128'(a_in_ready), 128'(1));
    step();
    a_in_valid = 1'b0;
    #1 chk($sformatf("vecA%0d_early", idx), 128'(a_out_valid), 128'(0));
    step();
    chk($sformatf("vecA%0d_valid", idx), 128'(a_out_valid), 128'(1));
    chk($sformatf("vecA%0d_data", idx), a_out_data, v.dout);
    chk($sformatf("vecA%0d_last", idx), 128'(a_out_last), 128'(idx[0]));
    step();
    chk($sformatf("vecA%0d_pulse", idx), 128'(a_out_valid), 128'(0));
  endtask

  task automatic apply_vec_b(input vec_t v, input int idx);
    b_in_valid = 1'b1; b_in_data = v.din[31:0]; b_in_inv = v.inv; b_in_bypass = v.byp;
    b_in_last = idx[0]; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    step();
    chk($sformatf("vecB%0d_valid", idx), 128'(b_out_valid), 128'(1));
    chk($sformatf("vecB%0d_data", idx), 128'(b_out_data), v.dout);
    chk($sformatf("vecB%0d_last", idx), 128'(b_out_last), 128'(idx[0]));
    step();
    chk($sformatf("vecB%0d_pulse", idx), 128'(b_out_valid), 128'(0));
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl_a[4];
  vec_t tbl_b[5];

  initial begin
    bit ir, ov;
    int cnt_base, out_base, guard;
    logic [127:0] rd;
    int m;

    tbl_a[0] = '{128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5, 1'b0, 1'b0,
                 128'h046681E5_E0CB199A_48F8D37A_2806264C};
    tbl_a[1] = '{128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5, 1'b1, 1'b1,
                 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5};
    tbl_a[2] = '{128'hDB135345_F20A225C_C6C6C6C6_01010101, 1'b0, 1'b0,
                 128'h8E4DA1BC_9FDC589D_C6C6C6C6_01010101};
    tbl_a[3] = '{128'h8E4DA1BC_9FDC589D_C6C6C6C6_01010101, 1'b1, 1'b0,
                 128'hDB135345_F20A225C_C6C6C6C6_01010101};

    tbl_b[0] = '{128'hDB135345, 1'b0, 1'b0, 128'h8E4DA1BC};
    tbl_b[1] = '{128'h8E4DA1BC, 1'b1, 1'b0, 128'hDB135345};
    tbl_b[2] = '{128'hF20A225C, 1'b0, 1'b0, 128'h9FDC589D};
    tbl_b[3] = '{128'h9FDC589D, 1'b1, 1'b0, 128'hF20A225C};
    tbl_b[4] = '{128'hC6C6C6C6, 1'b1, 1'b0, 128'hC6C6C6C6};

    a_in_valid = 0; a_in_data = '0; a_in_inv = 0; a_in_bypass = 0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_in_inv = 0; b_in_bypass = 0; b_in_last = 0; b_out_ready = 0;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_a_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_a_out_data", a_out_data, 128'(0));
    chk("rst_a_out_last", 128'(a_out_last), 128'(0));
    chk("rst_a_beat_cnt", 128'(a_beat_cnt), 128'(0));
    chk("rst_a_in_ready", 128'(a_in_ready), 128'(1));
    chk("rst_b_out_valid", 128'(b_out_valid), 128'(0));
    chk("rst_b_beat_cnt", 128'(b_beat_cnt), 128'(0));

    // Known-answer tables
    for (int i = 0; i < 4; i++) apply_vec_a(tbl_a[i], i);
    chk("vecA_beat_cnt", 128'(a_beat_cnt), 128'(4));
    for (int i = 0; i < 5; i++) begin
      apply_vec_b(tbl_b[i], i);
      if (i == 1) chk("vecB_cnt_2", 128'(b_beat_cnt), 128'(2));
    end
    chk("vecB_cnt_sat", 128'(b_beat_cnt), 128'(3));

    // Reset with both stages full discards the beats
    push_beat(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b0, 1'b1);
    push_beat(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle_a(1'b1, 1'b0, ir, ov);
      if (i == 2) begin
        chk("full_in_ready", 128'(ir), 128'(0));
        chk("full_out_valid", 128'(ov), 128'(1));
      end
    end
    rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst2_out_data", a_out_data, 128'(0));
    chk("rst2_out_last", 128'(a_out_last), 128'(0));
    chk("rst2_beat_cnt", 128'(a_beat_cnt), 128'(0));
    chk("rst2_in_ready", 128'(a_in_ready), 128'(1));
    chk("rst2_b_beat_cnt", 128'(b_beat_cnt), 128'(0));
    a_out_ready = 1'b1;
    step();
    chk("rst2_no_ghost1", 128'(a_out_valid), 128'(0));
    step();
    chk("rst2_no_ghost2", 128'(a_out_valid), 128'(0));
    src_q.delete(); exp_q.delete(); stall_prev = 1'b0;

    // Back-to-back 8 beats, alternating fwd/inv/bypass
    for (int i = 0; i < 8; i++)
      push_beat({$urandom, $urandom, $urandom, $urandom}, (i % 3) == 1, (i % 3) == 2, i[0]);
    for (int i = 0; i < 11; i++) begin
      cycle_a(1'b1, 1'b1, ir, ov);
      if (i < 8) chk($sformatf("b2b_in_ready%0d", i), 128'(ir), 128'(1));
      chk($sformatf("b2b_out_valid%0d", i), 128'(ov), 128'((i >= 2) && (i <= 9)));
    end
    chk("b2b_beat_cnt", 128'(a_beat_cnt), 128'(8));
    chk("b2b_drained", 128'(exp_q.size()), 128'(0));

    // Output stall for 5 cycles while input keeps offering
    cnt_base = int'(a_beat_cnt);
    out_base = n_out;
    for (int i = 0; i < 4; i++)
      push_beat({$urandom, $urandom, $urandom, $urandom}, i[0], 1'b0, ~i[0]);
    for (int i = 0; i < 5; i++) begin
      cycle_a(1'b1, 1'b0, ir, ov);
      chk($sformatf("stall_in_ready%0d", i), 128'(ir), 128'(i < 2));
      if (i >= 2) chk($sformatf("stall_out_valid%0d", i), 128'(ov), 128'(1));
    end
    guard = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 20) begin
      cycle_a(1'b1, 1'b1, ir, ov);
      guard++;
    end
    for (int i = 0; i < 3; i++) cycle_a(1'b0, 1'b1, ir, ov);
    chk("stall_out_count", 128'(n_out - out_base), 128'(4));
    chk("stall_beat_cnt", 128'(int'(a_beat_cnt) - cnt_base), 128'(4));

    // Randomized traffic with random backpressure
    cnt_base = int'(a_beat_cnt);
    out_base = n_out;
    for (int i = 0; i < 300; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      m = $urandom_range(0, 2);
      push_beat(rd, (m == 1) || (m == 2 && $urandom_range(0, 1) == 1), m == 2, $urandom_range(0, 1) == 1);
    end
    guard = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 5000) begin
      cycle_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ir, ov);
      guard++;
    end
    if (src_q.size() > 0 || exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL rand_timeout: got %0d beats pending expected 0", src_q.size() + exp_q.size());
    end
    chk("rand_out_count", 128'(n_out - out_base), 128'(300));
    chk("rand_beat_cnt", 128'(int'(a_beat_cnt) - cnt_base), 128'(300));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
